i2c_slave_eeprom: RTL

I2C responder that emulates a 256-byte AT24C02-style EEPROM on the FPGA. It is the target for the on-chip I2C master configuration sequence: it loops master bring-up and regression on the board without an external EEPROM. It oversamples SCL/SDA with clk_12m, acknowledges its device address, holds a byte pointer and serves byte/sequential writes and current/random/sequential reads.

---
 rtl/i2c_slave_eeprom_if.sv | 21 ++
 rtl/i2c_slave_eeprom.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_eeprom_if.sv
// Status and clock bundle between the I2C EEPROM responder and its host logic.
// SDA stays a plain inout on the responder so open-drain resolution happens at one net.
interface i2c_slave_eeprom_if;
    logic       scl;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] mem_00_data;
    logic       busy;
    logic [3:0] state_debug;

    modport slave (
        input  scl,
        output wr_strobe, wr_addr, wr_data, mem_00_data, busy, state_debug
    );

    modport master (
        output scl,
        input  wr_strobe, wr_addr, wr_data, mem_00_data, busy, state_debug
    );
endinterface

// File: rtl/i2c_slave_eeprom.sv
// AT24C02-style 256-byte I2C EEPROM responder, oversampling SCL/SDA on clk_12m.
// state    | meaning
// IDLE     | bus free, waiting for START
// DEV_ADDR | shifting in device address + R/W
// DEV_ACK  | acknowledging our device address
// REG_ADDR | shifting in byte pointer
// REG_ACK  | acknowledging pointer
// WR_DATA  | shifting in a data byte to store
// WR_ACK   | acknowledging stored byte
// RD_DATA  | driving mem[pointer] MSB first
// RD_ACK   | released SDA, sampling master ACK/NACK
// IGNORE   | not addressed or read ended, wait for START/STOP
module i2c_slave_eeprom #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic              clk_12m,
    input  logic              rst_n,
    inout  wire               sda,
    i2c_slave_eeprom_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_DEV_ADDR = 4'd1,
        S_DEV_ACK  = 4'd2,
        S_REG_ADDR = 4'd3,
        S_REG_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    state_t     state, state_nxt;
    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] ptr, ptr_nxt;
    logic       sda_low, sda_low_nxt;
    logic       nine_seen, nine_nxt;
    logic       busy, busy_nxt;
    logic       rw, rw_nxt;
    logic       store_en;
    logic [7:0] byte_in;
    logic [7:0] mem [256];
    logic       wr_strobe;
    logic [7:0] wr_addr, wr_data;

    // Synchronizers idle high so reset release never fakes a START/STOP.
    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= bus.scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign byte_in   = {shift[6:0], sda_s2};

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            ptr       <= 8'h00;
            sda_low   <= 1'b0;
            nine_seen <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            ptr       <= ptr_nxt;
            sda_low   <= sda_low_nxt;
            nine_seen <= nine_nxt;
            busy      <= busy_nxt;
            rw        <= rw_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        ptr_nxt     = ptr;
        sda_low_nxt = sda_low;
        nine_nxt    = nine_seen;
        busy_nxt    = busy;
        rw_nxt      = rw;
        store_en    = 1'b0;
        if (stop_det) begin
            state_nxt   = S_IDLE;
            sda_low_nxt = 1'b0;
            busy_nxt    = 1'b0;
            bit_cnt_nxt = 3'd0;
        end else if (start_det) begin
            state_nxt   = S_DEV_ADDR;
            sda_low_nxt = 1'b0;
            bit_cnt_nxt = 3'd0;
        end else begin
            case (state)
                S_DEV_ADDR, S_REG_ADDR, S_WR_DATA: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            nine_nxt = 1'b0;
                            if (state == S_DEV_ADDR) begin
                                if (shift[6:0] == DEV_ADDR) begin
                                    state_nxt = S_DEV_ACK;
                                    rw_nxt    = sda_s2;
                                    busy_nxt  = 1'b1;
                                end else begin
                                    state_nxt = S_IGNORE;
                                    busy_nxt  = 1'b0;
                                end
                            end else if (state == S_REG_ADDR) begin
                                state_nxt = S_REG_ACK;
                                ptr_nxt   = byte_in;
                            end else begin
                                state_nxt = S_WR_ACK;
                                store_en  = 1'b1;
                                ptr_nxt   = ptr + 8'd1;
                            end
                        end
                    end
                end
                // The first fall after the 8th bit starts the ACK, the fall after the 9th ends it.
                S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
                    if (scl_rise) begin
                        nine_nxt = 1'b1;
                    end else if (scl_fall && !nine_seen) begin
                        sda_low_nxt = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_nxt = 3'd0;
                        sda_low_nxt = 1'b0;
                        if (state == S_DEV_ACK && rw) begin
                            state_nxt   = S_RD_DATA;
                            shift_nxt   = mem[ptr];
                            sda_low_nxt = ~mem[ptr][7];
                        end else if (state == S_DEV_ACK) begin
                            state_nxt = S_REG_ADDR;
                        end else begin
                            state_nxt = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt = S_RD_ACK;
                            ptr_nxt   = ptr + 8'd1;
                            nine_nxt  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shift_nxt   = {shift[6:0], 1'b0};
                        sda_low_nxt = ~shift[6];
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        nine_nxt = 1'b1;
                        if (sda_s2) begin
                            state_nxt = S_IGNORE;
                            busy_nxt  = 1'b0;
                        end
                    end else if (scl_fall && !nine_seen) begin
                        sda_low_nxt = 1'b0;
                    end else if (scl_fall) begin
                        state_nxt   = S_RD_DATA;
                        bit_cnt_nxt = 3'd0;
                        shift_nxt   = mem[ptr];
                        sda_low_nxt = ~mem[ptr][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (store_en) begin
            mem[ptr] <= byte_in;
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= store_en;
            if (store_en) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
            end
        end
    end

    assign sda             = sda_low ? 1'b0 : 1'bz;
    assign bus.wr_strobe   = wr_strobe;
    assign bus.wr_addr     = wr_addr;
    assign bus.wr_data     = wr_data;
    assign bus.mem_00_data = mem[0];
    assign bus.busy        = busy;
    assign bus.state_debug = state;

endmodule
